adder_delay_meter: RTL and testbench

//  Sequencer and ring-edge counter placed upstream/downstream of wrapped_instrumented_adder.
//  - Latches operands a/b from the LA bus and drives them to the adder.
//  - Enables the adder's ring loop, counts synchronised ring edges over a programmable

---
 rtl/adder_meter_pkg.sv | 23 ++
 rtl/ring_edge_sync.sv | 35 +++
 rtl/adder_delay_meter.sv | 153 +++++++++++++++
 tb/tb_adder_delay_meter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_meter_pkg.sv
// ============================================================================
// adder_meter_pkg : shared state encoding and default widths for the meter
// Rev 1.0
// ============================================================================
`default_nettype none

package adder_meter_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_CNT_W  = 32;
    localparam int DEF_GATE_W = 16;
    localparam int DEF_SETTLE = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/ring_edge_sync.sv
// ============================================================================
// ring_edge_sync : 2-flop synchroniser plus a one-cycle rising-edge pulse
// Rev 1.0
// ============================================================================
`default_nettype none

module ring_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic meta;
    logic sync_q;
    logic sync_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            sync_q <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= async_in;
            sync_q <= meta;
            sync_d <= sync_q;
        end
    end

    // Rings at or above half the clock rate alias and are undercounted.
    assign rise = sync_q & ~sync_d;

endmodule

`default_nettype wire

// File: rtl/adder_delay_meter.sv
// ============================================================================
// adder_delay_meter : latches adder operands, closes the ring loop and counts
// ring edges over a programmable gate window.            Rev 1.0
// ============================================================================
`default_nettype none

module adder_delay_meter
    import adder_meter_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int GATE_W        = DEF_GATE_W,
    parameter int SETTLE_CYCLES = DEF_SETTLE
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n,
    input  logic              start,
    input  logic [WIDTH-1:0]  a_in,
    input  logic [WIDTH-1:0]  b_in,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic              ring_in,
    output logic [WIDTH-1:0]  a_input,
    output logic [WIDTH-1:0]  b_input,
    output logic              ring_en,
    output logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic              rst_meta;
    logic              rst_sync_n;
    logic              start_q;
    logic              start_qq;
    logic              start_rise;
    logic              ring_rise;
    logic [SET_W-1:0]  settle_ctr;
    logic [GATE_W-1:0] win_ctr;
    logic [GATE_W-1:0] win_next;
    logic [GATE_W-1:0] gate_r;
    logic              settle_last;
    logic              win_last;
    state_t            state;
    state_t            state_next;

    // Reset asserts immediately, releases two clocks after wb_rst_n rises.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            rst_meta   <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta   <= 1'b1;
            rst_sync_n <= rst_meta;
        end
    end

    ring_edge_sync u_ring_sync (
        .clk      (wb_clk_i),
        .rst_n    (rst_sync_n),
        .async_in (ring_in),
        .rise     (ring_rise)
    );

    assign start_rise  = start_q & ~start_qq;
    assign win_next    = win_ctr + 1'b1;
    assign settle_last = (settle_ctr == SET_W'(SETTLE_CYCLES - 1));
    assign win_last    = (win_next == gate_r);

    always_ff @(posedge wb_clk_i or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start_rise) state_next = SETTLE;
            end
            SETTLE: begin
                busy = 1'b1;
                if (settle_last) state_next = (gate_r == '0) ? DONE : MEASURE;
            end
            MEASURE: begin
                busy = 1'b1;
                if (win_last) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start_rise) state_next = SETTLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            start_q    <= 1'b0;
            start_qq   <= 1'b0;
            a_input    <= '0;
            b_input    <= '0;
            gate_r     <= '0;
            ring_en    <= 1'b0;
            count      <= '0;
            overflow   <= 1'b0;
            settle_ctr <= '0;
            win_ctr    <= '0;
        end else begin
            start_q  <= start;
            start_qq <= start_q;
            case (state)
                IDLE, DONE: begin
                    if (start_rise) begin
                        a_input    <= a_in;
                        b_input    <= b_in;
                        gate_r     <= gate_cycles;
                        ring_en    <= 1'b1;
                        settle_ctr <= '0;
                    end
                end
                SETTLE: begin
                    settle_ctr <= settle_ctr + 1'b1;
                    if (settle_last) begin
                        count    <= '0;
                        overflow <= 1'b0;
                        win_ctr  <= '0;
                        if (gate_r == '0) ring_en <= 1'b0;
                    end
                end
                MEASURE: begin
                    // Saturate rather than wrap so a fast ring cannot read as slow.
                    if (ring_rise) begin
                        if (&count) overflow <= 1'b1;
                        else        count    <= count + 1'b1;
                    end
                    win_ctr <= win_next;
                    if (win_last) ring_en <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_adder_delay_meter.sv
// ============================================================================
// tb_adder_delay_meter : scoreboard bench for adder_delay_meter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_adder_delay_meter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start0 = 1'b0;
    logic        start4 = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic [15:0] gate = '0;
    logic        ring = 1'b0;
    int          ring_half = 40;

    logic [31:0] a0, b0, cnt0;
    logic        ren0, busy0, done0, ovf0;
    logic [31:0] a4, b4;
    logic [3:0]  cnt4;
    logic        ren4, busy4, done4, ovf4;

    typedef struct {
        logic [31:0] cnt;
        logic        ovf;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        int          hi;
        int          s0;
    } exp_t;

    exp_t q0[$];
    exp_t q4[$];
    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;
    int   hi0 = 0, hi4 = 0;
    logic d0p = 1'b0, d4p = 1'b0;

    adder_delay_meter #(.WIDTH(32), .CNT_W(32), .GATE_W(16), .SETTLE_CYCLES(4)) dut (
        .wb_clk_i(clk), .wb_rst_n(rst_n), .start(start0), .a_in(a_in), .b_in(b_in),
        .gate_cycles(gate), .ring_in(ring), .a_input(a0), .b_input(b0),
        .ring_en(ren0), .count(cnt0), .busy(busy0), .done(done0), .overflow(ovf0)
    );

    adder_delay_meter #(.WIDTH(32), .CNT_W(4), .GATE_W(16), .SETTLE_CYCLES(4)) dut4 (
        .wb_clk_i(clk), .wb_rst_n(rst_n), .start(start4), .a_in(a_in), .b_in(b_in),
        .gate_cycles(gate), .ring_in(ring), .a_input(a4), .b_input(b4),
        .ring_en(ren4), .count(cnt4), .busy(busy4), .done(done4), .overflow(ovf4)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #3;
        forever begin
            #(ring_half);
            ring = ~ring;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_done(input exp_t e, input logic [31:0] c, input logic o,
                              input logic [31:0] a, input logic [31:0] b, input int hi);
        chk("count", 64'(c), 64'(e.cnt));
        chk("overflow", 64'(o), 64'(e.ovf));
        chk("a_input", 64'(a), 64'(e.a));
        chk("b_input", 64'(b), 64'(e.b));
        chk("latency", 64'(cyc - e.s0), 64'(e.lat));
        chk("ring_en_cycles", 64'(hi), 64'(e.hi));
    endtask

    // Monitor: on every rising done, pop the expected result and compare.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            hi0 = 0; hi4 = 0; d0p = 1'b0; d4p = 1'b0;
        end else begin
            if (ren0) hi0++;
            if (ren4) hi4++;
            if (done0 && !d0p) begin
                if (q0.size() == 0) chk("unexpected_done0", 64'd1, 64'd0);
                else check_done(q0.pop_front(), cnt0, ovf0, a0, b0, hi0);
                hi0 = 0;
            end
            if (done4 && !d4p) begin
                if (q4.size() == 0) chk("unexpected_done4", 64'd1, 64'd0);
                else check_done(q4.pop_front(), 32'(cnt4), ovf4, a4, b4, hi4);
                hi4 = 0;
            end
            d0p = done0;
            d4p = done4;
        end
    end

    task automatic launch(input bit sel4, input logic [31:0] a, input logic [31:0] b,
                          input logic [15:0] g, input logic [31:0] ecnt, input logic eovf);
        exp_t e;
        repeat (3) @(negedge clk);
        a_in = a; b_in = b; gate = g;
        if (sel4) start4 = 1'b1; else start0 = 1'b1;
        @(posedge clk);
        #1;
        e.cnt = ecnt; e.ovf = eovf; e.a = a; e.b = b;
        e.lat = 4 + int'(g) + 1; e.hi = 4 + int'(g); e.s0 = cyc;
        if (sel4) q4.push_back(e); else q0.push_back(e);
    endtask

    // Start stays high through the whole run: only one measurement may result.
    task automatic wait_done(input bit sel4);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ((sel4 ? q4.size() : q0.size()) == 0) begin ok = 1'b1; break; end
        end
        if (!ok) chk("done_timeout", 64'd0, 64'd1);
        repeat (5) @(negedge clk);
        start0 = 1'b0; start4 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset held with the ring toggling
        repeat (10) @(negedge clk);
        chk("rst_a_input", 64'(a0), 64'd0);
        chk("rst_b_input", 64'(b0), 64'd0);
        chk("rst_ring_en", 64'(ren0), 64'd0);
        chk("rst_count", 64'(cnt0), 64'd0);
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_done", 64'(done0), 64'd0);
        chk("rst_overflow", 64'(ovf0), 64'd0);
        chk("rst_count4", 64'(cnt4), 64'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        ring_half = 40;
        launch(1'b0, 32'h1234_5678, 32'h9abc_def0, 16'd64, 32'd8, 1'b0);
        wait_done(1'b0);

        launch(1'b0, 32'h0000_0001, 32'hffff_ffff, 16'd0, 32'd0, 1'b0);
        wait_done(1'b0);

        ring_half = 20;
        repeat (20) @(negedge clk);
        launch(1'b0, 32'h5555_aaaa, 32'h0f0f_f0f0, 16'd40, 32'd10, 1'b0);
        wait_done(1'b0);

        launch(1'b1, 32'h0000_00a5, 32'h0000_005a, 16'd100, 32'd15, 1'b1);
        wait_done(1'b1);

        ring_half = 40;
        repeat (20) @(negedge clk);
        launch(1'b1, 32'h0000_0003, 32'h0000_0004, 16'd16, 32'd2, 1'b0);
        wait_done(1'b1);

        // Start re-pulsed mid-MEASURE with new operands: must be ignored
        launch(1'b0, 32'hdead_beef, 32'h0000_0001, 16'd64, 32'd8, 1'b0);
        repeat (10) @(negedge clk);
        start0 = 1'b0;
        repeat (10) @(negedge clk);
        a_in = 32'h0bad_f00d;
        start0 = 1'b1;
        repeat (3) @(negedge clk);
        start0 = 1'b0;
        wait_done(1'b0);
        repeat (40) @(negedge clk);
        chk("a_input_held", 64'(a0), 64'hdead_beef);

        // Reset mid-MEASURE, then a fresh measurement
        @(negedge clk);
        a_in = 32'h1111_2222; gate = 16'd64;
        start0 = 1'b1;
        repeat (20) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_ring_en", 64'(ren0), 64'd0);
        chk("midrst_busy", 64'(busy0), 64'd0);
        chk("midrst_count", 64'(cnt0), 64'd0);
        start0 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        launch(1'b0, 32'h7777_8888, 32'h9999_0000, 16'd32, 32'd4, 1'b0);
        wait_done(1'b0);

        repeat (50) @(negedge clk);
        chk("q0_drained", 64'(q0.size()), 64'd0);
        chk("q4_drained", 64'(q4.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
